// File: rtl/obstacle_spawner.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_spawner
// Description : Obstacle slot manager for the runner game. It scrolls active
//               obstacles left once per frame, derives difficulty from
//               time_alive, and spawns new obstacles after a random frame
//               delay with per-lane spacing at the spawn edge.
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_spawner #(
    parameter int NUM_SLOTS    = 10,
    parameter int NUM_LANES    = 3,
    parameter int LANE_W       = 2,
    parameter int POS_W        = 11,
    parameter int START_POS    = 1087,
    parameter int MIN_GAP      = 128,
    parameter int LEVEL_PERIOD = 30,
    parameter int MAX_LEVEL    = 10,
    parameter int BASE_SPEED   = 1,
    parameter int MAX_SPEED    = 7,
    parameter int SPD_W        = 3,
    parameter int WAIT_SCALE   = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          game_reset,
    input  logic                          run,
    input  logic                          frame_trigger,
    input  logic [11:0]                   time_alive,
    input  logic [3:0]                    random_num,
    input  logic [LANE_W-1:0]             random_lane,
    input  logic [1:0]                    random_sprite,
    output logic [NUM_SLOTS-1:0]          obs_active,
    output logic [NUM_SLOTS*LANE_W-1:0]   obs_lane,
    output logic [NUM_SLOTS*POS_W-1:0]    obs_pos,
    output logic [NUM_SLOTS*2-1:0]        obs_sprite,
    output logic [3:0]                    active_count,
    output logic [SPD_W-1:0]              speed,
    output logic [3:0]                    level,
    output logic                          spawn_pulse,
    output logic [3:0]                    spawn_slot
);

    localparam int WAIT_W = 4 + $clog2(WAIT_SCALE + 1);

    localparam logic [POS_W-1:0] c_start      = POS_W'(START_POS);
    localparam logic [POS_W-1:0] c_block_edge = POS_W'(START_POS - MIN_GAP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_PLACE = 2'd2;

    logic                 w_clear;
    logic                 w_frame;

    logic [NUM_SLOTS-1:0] r_active;
    logic [LANE_W-1:0]    r_lane   [NUM_SLOTS];
    logic [POS_W-1:0]     r_pos    [NUM_SLOTS];
    logic [1:0]           r_sprite [NUM_SLOTS];
    logic [3:0]           r_active_count;
    logic [3:0]           r_level;
    logic [SPD_W-1:0]     r_speed;
    logic [3:0]           r_target;
    logic                 r_spawn_pulse;
    logic [3:0]           r_spawn_slot;
    logic [1:0]           r_state;
    logic [WAIT_W-1:0]    r_wait;

    logic [11:0]          w_quot;
    logic [3:0]           w_level;
    logic [4:0]           w_spd_sum;
    logic [SPD_W-1:0]     w_speed;
    logic [3:0]           w_target;
    logic [3:0]           w_popcnt;
    logic [POS_W-1:0]     w_spd_ext;

    logic [NUM_LANES-1:0] w_blocked;
    logic                 w_lane_ok;
    logic [LANE_W-1:0]    w_lane_sel;
    logic                 w_free_ok;
    logic [3:0]           w_free_idx;

    logic [1:0]           w_state_nxt;
    logic [WAIT_W-1:0]    w_wait_nxt;
    logic                 w_spawn;

    assign w_clear   = rst_in | game_reset;
    assign w_frame   = frame_trigger & run;
    assign w_spd_ext = POS_W'(r_speed);

    // Difficulty is a pure function of time_alive, registered once.
    assign w_quot    = time_alive / 12'(LEVEL_PERIOD);
    assign w_level   = (w_quot > 12'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : w_quot[3:0];
    assign w_spd_sum = 5'(BASE_SPEED) + {1'b0, w_level};
    assign w_speed   = (w_spd_sum > 5'(MAX_SPEED)) ? SPD_W'(MAX_SPEED) : w_spd_sum[SPD_W-1:0];
    assign w_target  = (w_level > 4'(NUM_SLOTS)) ? 4'(NUM_SLOTS) : w_level;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_popcnt = w_popcnt + 4'(r_active[i]);
        end
    end

    // Lane and slot selection look only at registered slot state, so a slot
    // freed by movement this cycle becomes eligible on the following cycle.
    always_comb begin
        int cand;
        int lane;
        w_blocked  = '0;
        w_lane_ok  = 1'b0;
        w_lane_sel = '0;
        w_free_ok  = 1'b0;
        w_free_idx = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (r_active[i] && (int'(r_lane[i]) == l) && (r_pos[i] > c_block_edge)) begin
                    w_blocked[l] = 1'b1;
                end
            end
        end
        cand = int'(random_lane);
        if (cand >= NUM_LANES) begin
            cand = cand - NUM_LANES;
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            lane = cand + k;
            if (lane >= NUM_LANES) begin
                lane = lane - NUM_LANES;
            end
            if (!w_lane_ok && !w_blocked[lane]) begin
                w_lane_ok  = 1'b1;
                w_lane_sel = LANE_W'(lane);
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!w_free_ok && !r_active[i]) begin
                w_free_ok  = 1'b1;
                w_free_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_spawn     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_active_count < r_target) begin
                    w_wait_nxt  = WAIT_W'(random_num) * WAIT_W'(WAIT_SCALE);
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_frame) begin
                    if (r_wait == '0) begin
                        w_state_nxt = S_PLACE;
                    end else begin
                        w_wait_nxt = r_wait - WAIT_W'(1);
                    end
                end
            end
            S_PLACE: begin
                if (w_free_ok && w_lane_ok) begin
                    w_spawn     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_clear) begin
            r_state        <= S_IDLE;
            r_wait         <= '0;
            r_level        <= '0;
            r_speed        <= SPD_W'(BASE_SPEED);
            r_target       <= '0;
            r_active_count <= '0;
            r_spawn_pulse  <= 1'b0;
            r_spawn_slot   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_wait         <= w_wait_nxt;
            r_level        <= w_level;
            r_speed        <= w_speed;
            r_target       <= w_target;
            r_active_count <= w_popcnt;
            r_spawn_pulse  <= w_spawn;
            if (w_spawn) begin
                r_spawn_slot <= w_free_idx;
            end
        end
    end

    // Movement only touches active slots and spawning only an inactive one,
    // so the two updates never collide on the same slot.
    always_ff @(posedge clk_in) begin
        if (w_clear) begin
            r_active <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_pos[i]    <= c_start;
                r_lane[i]   <= '0;
                r_sprite[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_frame && r_active[i]) begin
                    if (r_pos[i] <= w_spd_ext) begin
                        r_active[i] <= 1'b0;
                        r_pos[i]    <= c_start;
                    end else begin
                        r_pos[i] <= r_pos[i] - w_spd_ext;
                    end
                end else if (w_spawn && (w_free_idx == 4'(i))) begin
                    r_active[i] <= 1'b1;
                    r_lane[i]   <= w_lane_sel;
                    r_pos[i]    <= c_start;
                    r_sprite[i] <= random_sprite;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot_out
            assign obs_lane[i*LANE_W +: LANE_W] = r_lane[i];
            assign obs_pos[i*POS_W +: POS_W]    = r_pos[i];
            assign obs_sprite[i*2 +: 2]         = r_sprite[i];
        end
    endgenerate

    assign obs_active   = r_active;
    assign active_count = r_active_count;
    assign speed        = r_speed;
    assign level        = r_level;
    assign spawn_pulse  = r_spawn_pulse;
    assign spawn_slot   = r_spawn_slot;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_spawner.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_spawner
// Description : Randomised self-checking bench for obstacle_spawner against a
//               behavioural game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_spawner;

    localparam int NS    = 10;
    localparam int NL    = 3;
    localparam int LW    = 2;
    localparam int PW    = 11;
    localparam int START = 1087;
    localparam int GAP   = 128;
    localparam int LP    = 30;
    localparam int ML    = 10;
    localparam int BS    = 1;
    localparam int MS    = 7;
    localparam int WS    = 4;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              game_reset;
    logic              run;
    logic              frame_trigger;
    logic [11:0]       time_alive;
    logic [3:0]        random_num;
    logic [LW-1:0]     random_lane;
    logic [1:0]        random_sprite;
    logic [NS-1:0]     obs_active;
    logic [NS*LW-1:0]  obs_lane;
    logic [NS*PW-1:0]  obs_pos;
    logic [NS*2-1:0]   obs_sprite;
    logic [3:0]        active_count;
    logic [2:0]        speed;
    logic [3:0]        level;
    logic              spawn_pulse;
    logic [3:0]        spawn_slot;

    always #5 clk_in = ~clk_in;

    obstacle_spawner #(
        .NUM_SLOTS(NS), .NUM_LANES(NL), .LANE_W(LW), .POS_W(PW),
        .START_POS(START), .MIN_GAP(GAP), .LEVEL_PERIOD(LP), .MAX_LEVEL(ML),
        .BASE_SPEED(BS), .MAX_SPEED(MS), .SPD_W(3), .WAIT_SCALE(WS)
    ) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .game_reset(game_reset), .run(run),
        .frame_trigger(frame_trigger), .time_alive(time_alive),
        .random_num(random_num), .random_lane(random_lane),
        .random_sprite(random_sprite), .obs_active(obs_active),
        .obs_lane(obs_lane), .obs_pos(obs_pos), .obs_sprite(obs_sprite),
        .active_count(active_count), .speed(speed), .level(level),
        .spawn_pulse(spawn_pulse), .spawn_slot(spawn_slot)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Game model: phase 0 = looking for room, 1 = counting down frames,
    // 2 = trying to place an obstacle.
    int m_act [NS];
    int m_pos [NS];
    int m_lane[NS];
    int m_spr [NS];
    int m_cnt, m_lvl, m_spd, m_tgt, m_ph, m_wait, m_pulse, m_slot;

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_pos[i] = START; m_lane[i] = 0; m_spr[i] = 0;
        end
        m_cnt = 0; m_lvl = 0; m_spd = BS; m_tgt = 0;
        m_ph = 0; m_wait = 0; m_pulse = 0; m_slot = 0;
    endtask

    task automatic m_step();
        int n_act[NS];
        int n_pos[NS];
        int n_lane[NS];
        int n_spr[NS];
        int frame, cnt, lvl, c, pick, free_s, l;
        bit blk;
        if (rst_in || game_reset) begin
            m_reset();
            return;
        end
        frame = (frame_trigger && run) ? 1 : 0;
        cnt = 0;
        for (int i = 0; i < NS; i++) begin
            cnt += m_act[i];
            n_act[i] = m_act[i]; n_pos[i] = m_pos[i];
            n_lane[i] = m_lane[i]; n_spr[i] = m_spr[i];
        end
        if (frame != 0) begin
            for (int i = 0; i < NS; i++) begin
                if (m_act[i] != 0) begin
                    if (m_pos[i] <= m_spd) begin
                        n_act[i] = 0; n_pos[i] = START;
                    end else begin
                        n_pos[i] = m_pos[i] - m_spd;
                    end
                end
            end
        end
        m_pulse = 0;
        if (m_ph == 0) begin
            if (m_cnt < m_tgt) begin
                m_ph = 1; m_wait = int'(random_num) * WS;
            end
        end else if (m_ph == 1) begin
            if (frame != 0) begin
                if (m_wait == 0) m_ph = 2;
                else m_wait--;
            end
        end else begin
            c = int'(random_lane) % NL;
            pick = -1;
            for (int k = 0; k < NL; k++) begin
                l = (c + k) % NL;
                blk = 0;
                for (int i = 0; i < NS; i++)
                    if (m_act[i] != 0 && m_lane[i] == l && m_pos[i] > START - GAP) blk = 1;
                if (!blk && pick < 0) pick = l;
            end
            free_s = -1;
            for (int i = NS - 1; i >= 0; i--)
                if (m_act[i] == 0) free_s = i;
            if (pick >= 0 && free_s >= 0) begin
                n_act[free_s] = 1; n_lane[free_s] = pick;
                n_pos[free_s] = START; n_spr[free_s] = int'(random_sprite);
                m_pulse = 1; m_slot = free_s; m_ph = 0;
            end
        end
        lvl = int'(time_alive) / LP;
        if (lvl > ML) lvl = ML;
        m_lvl = lvl;
        m_spd = (BS + lvl > MS) ? MS : BS + lvl;
        m_tgt = (lvl > NS) ? NS : lvl;
        m_cnt = cnt;
        for (int i = 0; i < NS; i++) begin
            m_act[i] = n_act[i]; m_pos[i] = n_pos[i];
            m_lane[i] = n_lane[i]; m_spr[i] = n_spr[i];
        end
    endtask

    task automatic compare_all();
        logic [NS-1:0] act;
        for (int i = 0; i < NS; i++) act[i] = (m_act[i] != 0);
        check("obs_active", obs_active, act);
        check("active_count", active_count, m_cnt);
        check("speed", speed, m_spd);
        check("level", level, m_lvl);
        check("spawn_pulse", spawn_pulse, m_pulse);
        check("spawn_slot", spawn_slot, m_slot);
        for (int i = 0; i < NS; i++) begin
            check($sformatf("pos%0d", i), obs_pos[i*PW +: PW], m_pos[i]);
            check($sformatf("lane%0d", i), obs_lane[i*LW +: LW], m_lane[i]);
            check($sformatf("sprite%0d", i), obs_sprite[i*2 +: 2], m_spr[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        m_step();
        #1;
        compare_all();
    endtask

    initial begin
        int frames;
        bit seen;
        rst_in = 1'b1; game_reset = 1'b0; run = 1'b1; frame_trigger = 1'b0;
        time_alive = '0; random_num = '0; random_lane = '0; random_sprite = '0;
        m_reset();
        tick();
        tick();
        rst_in = 1'b0;

        // No difficulty: nothing may ever spawn.
        for (int n = 0; n < 100; n++) begin
            frame_trigger = 1'b1;
            random_num = 4'($urandom_range(0, 15));
            random_lane = LW'($urandom_range(0, 3));
            random_sprite = 2'($urandom_range(0, 3));
            tick();
        end
        check("idle_count", active_count, 0);
        check("idle_speed", speed, 1);
        check("idle_level", level, 0);

        // Level 1, delay of 2*4 frames, lane 1.
        rst_in = 1'b1; frame_trigger = 1'b0;
        tick();
        rst_in = 1'b0;
        time_alive = 12'd30; random_num = 4'd2; random_lane = 2'd1; random_sprite = 2'd2;
        tick();
        check("lvl1_level", level, 1);
        check("lvl1_speed", speed, 2);
        tick();
        tick();
        frames = 0;
        seen = 0;
        frame_trigger = 1'b1;
        for (int n = 0; n < 200 && !seen; n++) begin
            if (frame_trigger) frames++;
            tick();
            if (spawn_pulse) seen = 1;
            frame_trigger = ~frame_trigger;
        end
        check("spawn_seen", seen, 1);
        check("frames_to_spawn", frames, 9);
        check("first_slot", spawn_slot, 0);
        check("first_lane", obs_lane[LW-1:0], 1);
        check("first_pos", obs_pos[PW-1:0], START);
        frame_trigger = 1'b1;
        tick();
        frame_trigger = 1'b0;
        check("first_move", obs_pos[PW-1:0], START - 2);

        // Randomised play with occasional resets and freezes.
        for (int n = 0; n < 20000; n++) begin
            if (n % 1500 == 0) begin
                case ($urandom_range(0, 5))
                    0: time_alive = 12'd4095;
                    1: time_alive = 12'd150;
                    2: time_alive = 12'd30;
                    3: time_alive = 12'($urandom_range(0, 4095));
                    default: time_alive = 12'd330;
                endcase
            end
            frame_trigger = 1'($urandom_range(0, 1));
            run = ($urandom_range(0, 9) != 0);
            random_num = 4'($urandom_range(0, 15));
            random_lane = LW'($urandom_range(0, 3));
            random_sprite = 2'($urandom_range(0, 3));
            rst_in = ($urandom_range(0, 699) == 0);
            game_reset = ($urandom_range(0, 699) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
